// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro sequencer: sequencing op codes,
// condition selects, FSM encoding and the condition evaluator.
package micro_sequencer_pkg;

    localparam int ADDR_W_DEF      = 10;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        OP_CONT     = 3'b000,
        OP_JUMP     = 3'b001,
        OP_CALL     = 3'b010,
        OP_RET      = 3'b011,
        OP_DISPATCH = 3'b100,
        OP_HALT     = 3'b101
    } op_e;

    localparam logic [3:0] COND_TRUE = 4'd0;
    localparam logic [3:0] COND_Z    = 4'd1;
    localparam logic [3:0] COND_NZ   = 4'd2;
    localparam logic [3:0] COND_N    = 4'd3;
    localparam logic [3:0] COND_NN   = 4'd4;
    localparam logic [3:0] COND_C    = 4'd5;
    localparam logic [3:0] COND_NC   = 4'd6;
    localparam logic [3:0] COND_V    = 4'd7;
    localparam logic [3:0] COND_NV   = 4'd8;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    // Selects 9-15 are deliberately "never taken".
    function automatic logic cond_eval(input logic [3:0] sel,
                                       input logic z, input logic n,
                                       input logic c, input logic v);
        logic res;
        case (sel)
            COND_TRUE: res = 1'b1;
            COND_Z:    res = z;
            COND_NZ:   res = !z;
            COND_N:    res = n;
            COND_NN:   res = !n;
            COND_C:    res = c;
            COND_NC:   res = !c;
            COND_V:    res = v;
            COND_NV:   res = !v;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/micro_stack.sv
// LIFO return-address stack for microsubroutines; only the occupancy
// count is reset, entry contents are don't-care until pushed.
module micro_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] count_m1;

    assign count_m1 = count - 1'b1;
    assign wr_idx   = IDX_W'(count);
    assign rd_idx   = IDX_W'(count_m1);
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign top      = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (push && !full)
            count <= count + 1'b1;
        else if (pop && !empty)
            count <= count_m1;
    end

    always_ff @(posedge clk) begin
        if (rst_n && push && !full)
            mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/micro_sequencer.sv
// Next-microaddress generator: holds the MPC and sequences it from the
// MIR Type/DAdd fields, datapath flags and macro-opcode.
//   state   | meaning
//   START   | MIR not yet valid, step MPC by one
//   RUN     | normal sequencing by MIR op
//   HALT    | MPC and stack frozen until reset
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [6:0]        Type_IN,
    input  logic [ADDR_W-1:0] DAdd_IN,
    input  logic [5:0]        Opcode_IN,
    input  logic              Z_IN,
    input  logic              N_IN,
    input  logic              C_IN,
    input  logic              V_IN,
    output logic [ADDR_W-1:0] MAddr_OUT,
    output logic              Halt_OUT,
    output logic              StackErr_OUT
);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] mpc;
    logic [ADDR_W-1:0] mpc_nxt;
    logic [ADDR_W-1:0] mpc_inc;
    logic [ADDR_W-1:0] stack_top;
    logic              stack_full;
    logic              stack_empty;
    logic              push;
    logic              pop;
    logic              halt_req;
    logic              err_set;
    logic              taken;
    logic              halt_q;
    logic              err_q;
    op_e               op;

    assign op      = op_e'(Type_IN[6:4]);
    assign taken   = cond_eval(Type_IN[3:0], Z_IN, N_IN, C_IN, V_IN);
    assign mpc_inc = mpc + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RST_N)
            state <= S_START;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_START: state_nxt = S_RUN;
            S_RUN:   state_nxt = halt_req ? S_HALT : S_RUN;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_START;
        endcase
    end

    always_comb begin
        mpc_nxt  = mpc;
        push     = 1'b0;
        pop      = 1'b0;
        halt_req = 1'b0;
        err_set  = 1'b0;
        case (state)
            S_START: mpc_nxt = mpc_inc;
            S_RUN: begin
                case (op)
                    OP_JUMP: mpc_nxt = taken ? DAdd_IN : mpc_inc;
                    OP_CALL: begin
                        if (!taken) begin
                            mpc_nxt = mpc_inc;
                        end else if (stack_full) begin
                            halt_req = 1'b1;
                            err_set  = 1'b1;
                        end else begin
                            push    = 1'b1;
                            mpc_nxt = DAdd_IN;
                        end
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            halt_req = 1'b1;
                            err_set  = 1'b1;
                        end else begin
                            pop     = 1'b1;
                            mpc_nxt = stack_top;
                        end
                    end
                    OP_DISPATCH: mpc_nxt = ADDR_W'({Opcode_IN, DAdd_IN[3:0]});
                    OP_HALT:     halt_req = 1'b1;
                    default:     mpc_nxt = mpc_inc;
                endcase
            end
            default: mpc_nxt = mpc;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mpc    <= '0;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mpc    <= mpc_nxt;
            halt_q <= (state_nxt == S_HALT);
            err_q  <= err_q | err_set;
        end
    end

    micro_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (push),
        .pop       (pop),
        .push_data (mpc_inc),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign MAddr_OUT    = mpc;
    assign Halt_OUT     = halt_q;
    assign StackErr_OUT = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: hand-computed MPC, halt and stack
// error values after each applied microinstruction.
module tb_micro_sequencer;

    localparam logic [6:0] T_CONT = 7'h00;
    localparam logic [6:0] T_JUMP = 7'h10;
    localparam logic [6:0] T_CALL = 7'h20;
    localparam logic [6:0] T_RET  = 7'h30;
    localparam logic [6:0] T_DISP = 7'h40;
    localparam logic [6:0] T_HALT = 7'h50;

    logic       clk;
    logic       rst_n;
    logic [6:0] type_in;
    logic [9:0] dadd;
    logic [5:0] opcode;
    logic       z, n, c, v;
    logic [9:0] maddr;
    logic       halt;
    logic       stack_err;

    int n_checks;
    int n_fail;

    micro_sequencer dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .Type_IN      (type_in),
        .DAdd_IN      (dadd),
        .Opcode_IN    (opcode),
        .Z_IN         (z),
        .N_IN         (n),
        .C_IN         (c),
        .V_IN         (v),
        .MAddr_OUT    (maddr),
        .Halt_OUT     (halt),
        .StackErr_OUT (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] exp_addr,
                         input logic exp_halt, input logic exp_err);
        n_checks++;
        assert (maddr === exp_addr) else begin
            n_fail++;
            $error("FAIL %s maddr: observed %h expected %h", tag, maddr, exp_addr);
        end
        n_checks++;
        assert (halt === exp_halt) else begin
            n_fail++;
            $error("FAIL %s halt: observed %b expected %b", tag, halt, exp_halt);
        end
        n_checks++;
        assert (stack_err === exp_err) else begin
            n_fail++;
            $error("FAIL %s stack_err: observed %b expected %b", tag, stack_err, exp_err);
        end
    endtask

    // flags = {Z, N, C, V}; apply one microinstruction for one clock edge
    task automatic step(input string tag, input logic [6:0] t, input logic [9:0] d,
                        input logic [5:0] o, input logic [3:0] flags,
                        input logic [9:0] exp_addr, input logic exp_halt,
                        input logic exp_err);
        type_in = t;
        dadd    = d;
        opcode  = o;
        {z, n, c, v} = flags;
        @(posedge clk);
        #1;
        check(tag, exp_addr, exp_halt, exp_err);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        type_in = T_CALL;
        dadd    = 10'h3C0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check(tag, 10'h000, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        type_in  = T_CONT;
        dadd     = '0;
        opcode   = '0;
        {z, n, c, v} = 4'b0000;

        do_reset("reset");
        step("start_ignores_jump", T_JUMP, 10'h2AA, 6'h00, 4'b0000, 10'h001, 1'b0, 1'b0);
        step("cont_2",             T_CONT, 10'h000, 6'h00, 4'b0000, 10'h002, 1'b0, 1'b0);
        step("cont_3",             T_CONT, 10'h000, 6'h00, 4'b0000, 10'h003, 1'b0, 1'b0);
        step("jump_z_taken",       T_JUMP | 7'd1,  10'h100, 6'h00, 4'b1000, 10'h100, 1'b0, 1'b0);
        step("jump_z_untaken",     T_JUMP | 7'd1,  10'h200, 6'h00, 4'b0000, 10'h101, 1'b0, 1'b0);
        step("jump_c12_never",     T_JUMP | 7'd12, 10'h200, 6'h00, 4'b1111, 10'h102, 1'b0, 1'b0);
        step("jump_c_taken",       T_JUMP | 7'd5,  10'h150, 6'h00, 4'b0010, 10'h150, 1'b0, 1'b0);
        step("jump_nv_untaken",    T_JUMP | 7'd8,  10'h300, 6'h00, 4'b0001, 10'h151, 1'b0, 1'b0);
        step("jump_n_taken",       T_JUMP | 7'd3,  10'h3FE, 6'h00, 4'b0100, 10'h3FE, 1'b0, 1'b0);
        step("reserved_op_cont",   7'h60,          10'h123, 6'h00, 4'b0000, 10'h3FF, 1'b0, 1'b0);
        step("wrap_to_0",          T_CONT,         10'h000, 6'h00, 4'b0000, 10'h000, 1'b0, 1'b0);
        step("jump_to_010",        T_JUMP,         10'h010, 6'h00, 4'b0000, 10'h010, 1'b0, 1'b0);
        step("call_200",           T_CALL,         10'h200, 6'h00, 4'b0000, 10'h200, 1'b0, 1'b0);
        step("call_body",          T_CONT,         10'h000, 6'h00, 4'b0000, 10'h201, 1'b0, 1'b0);
        step("ret_to_011",         T_RET,          10'h000, 6'h00, 4'b0000, 10'h011, 1'b0, 1'b0);
        step("dispatch_2b5",       T_DISP,         10'h3F5, 6'h2B, 4'b0000, 10'h2B5, 1'b0, 1'b0);

        step("nest_call_1",        T_CALL,         10'h100, 6'h00, 4'b0000, 10'h100, 1'b0, 1'b0);
        step("nest_call_2",        T_CALL,         10'h180, 6'h00, 4'b0000, 10'h180, 1'b0, 1'b0);
        step("nest_call_3",        T_CALL,         10'h200, 6'h00, 4'b0000, 10'h200, 1'b0, 1'b0);
        step("nest_call_4",        T_CALL,         10'h280, 6'h00, 4'b0000, 10'h280, 1'b0, 1'b0);
        step("nest_ret_4",         T_RET,          10'h000, 6'h00, 4'b0000, 10'h201, 1'b0, 1'b0);
        step("nest_ret_3",         T_RET,          10'h000, 6'h00, 4'b0000, 10'h181, 1'b0, 1'b0);
        step("nest_ret_2",         T_RET,          10'h000, 6'h00, 4'b0000, 10'h101, 1'b0, 1'b0);
        step("nest_ret_1",         T_RET,          10'h000, 6'h00, 4'b0000, 10'h2B6, 1'b0, 1'b0);

        step("fill_call_1",        T_CALL,         10'h040, 6'h00, 4'b0000, 10'h040, 1'b0, 1'b0);
        step("fill_call_2",        T_CALL,         10'h050, 6'h00, 4'b0000, 10'h050, 1'b0, 1'b0);
        step("fill_call_3",        T_CALL,         10'h060, 6'h00, 4'b0000, 10'h060, 1'b0, 1'b0);
        step("fill_call_4",        T_CALL,         10'h070, 6'h00, 4'b0000, 10'h070, 1'b0, 1'b0);
        step("overflow_call_5",    T_CALL,         10'h080, 6'h00, 4'b0000, 10'h070, 1'b1, 1'b1);
        step("ovf_frozen_cont",    T_CONT,         10'h000, 6'h00, 4'b0000, 10'h070, 1'b1, 1'b1);
        step("ovf_frozen_ret",     T_RET,          10'h000, 6'h00, 4'b0000, 10'h070, 1'b1, 1'b1);
        step("ovf_frozen_jump",    T_JUMP,         10'h155, 6'h00, 4'b0000, 10'h070, 1'b1, 1'b1);

        do_reset("reset_after_ovf");
        step("start_2",            T_CONT,         10'h000, 6'h00, 4'b0000, 10'h001, 1'b0, 1'b0);
        step("call_untaken_c9",    T_CALL | 7'd9,  10'h300, 6'h00, 4'b1111, 10'h002, 1'b0, 1'b0);
        step("underflow_ret",      T_RET,          10'h000, 6'h00, 4'b0000, 10'h002, 1'b1, 1'b1);
        step("unf_frozen",         T_CONT,         10'h000, 6'h00, 4'b0000, 10'h002, 1'b1, 1'b1);

        do_reset("reset_after_unf");
        step("start_3",            T_CONT,         10'h000, 6'h00, 4'b0000, 10'h001, 1'b0, 1'b0);
        step("halt_op",            T_HALT,         10'h3AA, 6'h00, 4'b0000, 10'h001, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            step("halt_frozen",    T_JUMP,         10'h155, 6'h15, 4'b1111, 10'h001, 1'b1, 1'b0);

        // Reset arriving with a CALL on the inputs must not leave a pushed entry.
        step("start_4_pre",        T_CONT,         10'h000, 6'h00, 4'b0000, 10'h001, 1'b1, 1'b0);
        do_reset("reset_mid_call");
        step("start_4",            T_CONT,         10'h000, 6'h00, 4'b0000, 10'h001, 1'b0, 1'b0);
        step("ret_after_reset",    T_RET,          10'h000, 6'h00, 4'b0000, 10'h001, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of stimulus, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Next-microaddress generator for the microprogrammed control unit. It holds the micro program counter (MPC) that addresses the control store, and computes the next MPC from the sequencing fields of the microinstruction currently held in the microinstruction register (Type, DAdd), the datapath flags and the macro-opcode. It sits upstream of the microinstruction register and consumes that register's Type/DAdd outputs, closing the control loop. It supports a 4-deep microsubroutine stack.

## Interface
- ADDR_W, 10, control-store address width (matches DAdd width)
- STACK_DEPTH, 4, microsubroutine return stack entries
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  synchronous, active-low reset, sampled on posedge CLK
- Type_IN  in  7  sequencing field from MIR: [6:4] op, [3:0] condition select
- DAdd_IN  in  10  direct/jump address field from MIR
- Opcode_IN  in  6  macro-instruction opcode from IR, for dispatch
- Z_IN, N_IN, C_IN, V_IN  in  1 each  datapath flags
- MAddr_OUT  out  10  registered MPC, drives control-store address
- Halt_OUT  out  1  high while in HALT
- StackErr_OUT  out  1  sticky; stack overflow/underflow occurred

## Operation
- Op encoding (Type_IN[6:4]): 000 CONT, 001 JUMP, 010 CALL, 011 RET, 100 DISPATCH, 101 HALT, 110/111 reserved = CONT.
- Condition (Type_IN[3:0]): 0 true, 1 Z, 2 !Z, 3 N, 4 !N, 5 C, 6 !C, 7 V, 8 !V, 9-15 false. Applies to JUMP and CALL only; RET, DISPATCH, HALT unconditional.
- CONT or untaken JUMP/CALL: MPC <= MPC+1, modulo 2^10 (1023 -> 0).
- Taken JUMP: MPC <= DAdd_IN.
- Taken CALL: push MPC+1 (mod 2^10), MPC <= DAdd_IN.
- RET: pop top of stack into MPC.
- DISPATCH: MPC <= {Opcode_IN, DAdd_IN[3:0]}.
- HALT op: enter HALT; MPC holds.
- CALL taken with STACK_DEPTH entries occupied: no push, StackErr_OUT <= 1, enter HALT, MPC holds. RET with empty stack: same.
- FSM states: START, RUN, HALT.
  - START: MIR content invalid; ignore Type/DAdd, MPC <= MPC+1, -> RUN.
  - RUN: sequence per op above.
  - HALT: MPC, stack frozen; Halt_OUT=1; left only by reset.
- Stack: LIFO with count 0..STACK_DEPTH; entries not reset (only count).

## Timing
- Reset (RST_N=0 at posedge): MPC=0, state=START, stack count=0, Halt_OUT=0, StackErr_OUT=0. Reset mid-operation behaves identically, discarding any push/pop in that cycle.
- MAddr_OUT is the MPC register: updates one cycle after the decision edge.
- Pipeline: MIR holds ROM(MPC-prev) while MPC already addresses the next word, so every JUMP/CALL/RET/DISPATCH has exactly one delay slot: the word at (branch address + 1) always executes. CALL return address MPC+1 therefore skips the delay slot.
- Flags and Opcode_IN sampled at the same edge as Type_IN/DAdd_IN; no internal flag registering.
- Halt_OUT and StackErr_OUT are registered, asserted the cycle MPC freezes.

## Structure
- Shared package: op codes (CONT, JUMP, CALL, RET, DISPATCH, HALT), condition-select codes, FSM state encoding, ADDR_W default.
- One sub-module natural: micro_stack (push/pop/count/full/empty, parameterised by depth and width). Condition mux and next-address mux stay in top.

## Test plan
- Reset then Type=CONT continuously -> MAddr_OUT 0,1,2,3...; preload MPC path to 1023 -> next 0.
- START: garbage Type=JUMP, DAdd=0x2AA on first cycle after reset -> MAddr_OUT=1, not 0x2AA.
- JUMP cond 1 with Z_IN=1, DAdd=0x100 -> MAddr_OUT=0x100; same with Z_IN=0 -> MPC+1; cond 12 -> never taken.
- CALL at MPC=0x010 (MIR shows CALL, DAdd=0x200) -> MAddr 0x200, later RET -> MAddr 0x011+... i.e. pushed value = MPC at decision +1; nest 4 CALLs then 4 RETs -> return in reverse order.
- 5th nested CALL -> StackErr_OUT=1, Halt_OUT=1, MPC frozen; RET on empty stack after reset -> same; RST_N=0 -> both clear, MPC=0.
- DISPATCH with Opcode_IN=0x2B, DAdd[3:0]=0x5 -> MAddr_OUT=0x2B5; HALT op -> Halt_OUT=1, MPC frozen across 10 cycles.
